ysyx_25030085_lsu: RTL and testbench
====================================

// Module: ysyx_25030085_lsu
// PURPOSE
// - Load/store unit: the producer side of the regfile write-back port for memory data (MemtoReg=01 path).
// - Takes one load/store from the single-cycle core and runs a valid/ready memory transaction.
// - Returns sign/zero-extended load data as a one-cycle write-back pulse {wb_valid, wb_rd, wb_data} for register[rd].
// PARAMETERS
// - ADDR_W  32  memory address width; mem_addr = addr[ADDR_W-1:0]
// PORTS
// - clk            in   1   core clock, all state on posedge
// - rst            in   1   asynchronous reset, ACTIVE-LOW (0 = reset)
// - req_valid      in   1   core presents a memory op
// - req_ready      out  1   LSU can accept (1 only in IDLE)
// - req_is_store   in   1   1 = store, 0 = load
// - req_funct3     in   3   RV32I funct3: LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010
// - req_addr       in   32  effective address (ALU result)
// - req_wdata      in   32  store data (Read_rs2)
// - req_rd         in   5   load destination register
// - mem_req_valid  out  1   memory request valid
// - mem_req_ready  in   1   memory accepts request
// - mem_we         out  1   1 = write
// - mem_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
// - mem_wdata      out  32  lane-replicated store data
// - mem_wmask      out  4   byte enables (0 for loads)
// - mem_rsp_valid  in   1   response/ack for the outstanding request
// - mem_rdata      in   32  raw read word
// - wb_valid       out  1   write-back pulse (RegWrite for load)
// - wb_rd          out  5   destination register
// - wb_data        out  32  extended load result
// - done           out  1   one-cycle pulse: op retired (load or store)
// - err            out  1   one-cycle pulse with done: misaligned op (LSU_MISALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; req_ready=1; mem_req_valid, mem_we, wb_valid, done, err=0; mem_addr, mem_wdata, mem_wmask, wb_rd, wb_data=0. Outstanding op discarded.
// - FSM IDLE -> REQ on req_valid&&req_ready; op fields captured in that edge. req_ready=0 outside IDLE.
// - REQ: mem_req_valid=1, all mem_* outputs stable until mem_req_ready=1; then -> WAIT. Never drops valid without handshake.
// - WAIT: on mem_rsp_valid -> RESP; mem_rdata latched for loads. mem_rsp_valid in IDLE/REQ/RESP is ignored.
// - RESP (1 cycle): done=1; load: wb_valid=1 unless rd==0 (wb_valid=0, done still 1); -> IDLE. Next op accepted the following cycle.
// - Minimum latency: accept edge + 1 cycle REQ + 1 cycle WAIT + RESP = done 3 cycles after accept, zero-wait memory.
// - Store lanes, a=addr[1:0]: SB mask 4'b0001<<a, wdata {4{b}}; SH mask 4'b0011<<{a[1],1'b0}, wdata {2{h}}; SW mask 4'b1111.
// - Load extract: byte = rdata[8a+:8], half = rdata[16*a[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
// - Unused funct3 (load 011/110/111, store 011-111): treated as LW/SW.
// CONFIGURATION
// - LSU_MISALIGN_CHECK_EN defined: half with a[0]=1 or word with a!=0 issues NO memory request; REQ->RESP directly, done=1, err=1, wb_valid=0.
// - Undefined: no check; low bits ignored per lane rules above (SH uses a[1], LW/SW use word); err tied 0.
// TESTING
// - SW addr=0x80000004 wdata=0xDEADBEEF, zero-wait mem -> mem_addr=0x80000004 mask=1111 wdata=0xDEADBEEF; done 3 cycles after accept, wb_valid=0.
// - LB addr=0x80000003 rdata=0x80FF1234 -> wb_data=0xFFFFFF80 wb_rd as sent; LBU same -> 0x00000080; LH addr=..2 -> 0xFFFF80FF.
// - SB addr=0x..01 wdata=0x000000AB -> mask=0010 wdata=0xABABABAB; SH addr=0x..02 wdata=0x1234 -> mask=1100 wdata=0x12341234.
// - mem_req_ready low 5 cycles, rsp 3 cycles later -> mem_* stable throughout, req_ready=0, single done/wb pulse.
// - LW rd=0 -> done=1 wb_valid=0; rst=0 asserted in WAIT -> all outputs 0 immediately, later rsp ignored, IDLE.
// - LSU_MISALIGN_CHECK_EN: LW addr=0x..02 -> no mem_req_valid, done=err=1, wb_valid=0; without macro -> reads word 0x..00.

Source files
------------

// File: rtl/ysyx_25030085_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_25030085_lsu -- load/store unit for the single-cycle core.
//
// Accepts one load or store from the core, runs one valid/ready memory
// transaction and then retires it with a one-cycle done pulse. Loads also
// produce a one-cycle write-back pulse {wb_valid, wb_rd, wb_data} carrying
// the sign/zero-extended result for register[rd] (suppressed for rd == 0).
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word ops issue no memory request and retire
//               with done=1, err=1, wb_valid=0.
//   undefined : low address bits are ignored per the lane rules; err stays 0.
//
// Parameters
//   ADDR_W         memory address width (<= 32)
// Ports
//   clk, rst       clock; asynchronous active-low reset (0 = reset)
//   req_*          core request: valid/ready, is_store, funct3, addr, wdata, rd
//   mem_req_*      memory request: valid/ready, we, addr (word aligned),
//                  wdata (lane replicated), wmask (0 for loads)
//   mem_rsp_valid  response/ack for the outstanding request, mem_rdata raw word
//   wb_valid/rd/data  load write-back pulse
//   done, err      retire pulse and misaligned-op flag (pulses with done)
// ----------------------------------------------------------------------------
module ysyx_25030085_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;

  // Operation fields captured on the accept edge.
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        mis_q;

  // Request-side decode (valid only while in IDLE).
  logic [1:0]  req_off;
  logic        req_is_byte;
  logic        req_is_half;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic        req_misalign;

  // Response-side extraction.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign req_ready = (state == S_IDLE);
  assign req_off   = req_addr[1:0];

  // Access size: byte/half encodings differ between loads (LBU/LHU) and
  // stores; every unused encoding falls through to a full word.
  assign req_is_byte = (req_funct3 == 3'b000) || (!req_is_store && req_funct3 == 3'b100);
  assign req_is_half = (req_funct3 == 3'b001) || (!req_is_store && req_funct3 == 3'b101);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = req_wdata;
    if (req_is_byte) begin
      st_mask  = 4'b0001 << req_off;
      st_wdata = {4{req_wdata[7:0]}};
    end else if (req_is_half) begin
      st_mask  = 4'b0011 << {req_off[1], 1'b0};
      st_wdata = {2{req_wdata[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misalign = req_is_half ? req_off[0] : (!req_is_byte && (req_off != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // Byte lane a sits at bits [8a +: 8]; the half-word lane is picked by a[1].
  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_value = mem_rdata;
    case (f3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      st_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      rd_q          <= 5'd0;
      mis_q         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'd0;
      mem_wmask     <= 4'b0000;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Retire outputs are single-cycle pulses.
      wb_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            st_q          <= req_is_store;
            f3_q          <= req_funct3;
            off_q         <= req_off;
            rd_q          <= req_rd;
            mis_q         <= req_misalign;
            mem_we        <= req_is_store;
            mem_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata     <= req_is_store ? st_wdata : 32'd0;
            mem_wmask     <= req_is_store ? st_mask : 4'b0000;
            // A misaligned op never shows a request to memory.
            mem_req_valid <= !req_misalign;
            state         <= S_REQ;
          end
        end

        S_REQ: begin
          if (mis_q) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_RESP;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mem_rsp_valid) begin
            done  <= 1'b1;
            state <= S_RESP;
            if (!st_q) begin
              wb_valid <= (rd_q != 5'd0);
              wb_rd    <= rd_q;
              wb_data  <= ld_value;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25030085_lsu -- scoreboard bench for the load/store unit.
//
// The stimulus process issues ops and pushes the expected memory request,
// the memory timing/data to return, and the expected retire response into
// queues. A responder process plays the memory, and a monitor process
// compares every presented memory request and every done pulse against the
// queues, including the cycle on which done must appear.
// ----------------------------------------------------------------------------
module tb_ysyx_25030085_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mreq_t;

  typedef struct {
    logic        wb_valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          acc_c;
    int          done_c;
  } rsp_t;

  typedef struct {
    int          rw;
    int          rdl;
    logic [31:0] rdata;
  } mt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  // Memory side is driven by the auto responder or by directed code.
  logic        auto_ready = 1'b0, man_ready = 1'b0;
  logic        auto_rsp = 1'b0, man_rsp = 1'b0;
  logic [31:0] auto_rdata = 32'd0, man_rdata = 32'd0;
  assign mem_req_ready = auto_ready | man_ready;
  assign mem_rsp_valid = auto_rsp | man_rsp;
  assign mem_rdata     = man_rsp ? man_rdata : auto_rdata;

  mreq_t mq[$];
  rsp_t  rq[$];
  mt_t   tq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_mem = 1'b1;
  bit chk_ready = 1'b1;

  ysyx_25030085_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic st, input logic [2:0] f3);
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic st, input logic [2:0] f3, input int a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (a % op_size(st, f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] rdata);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * a)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Issue one op: wait for req_ready, present it for one cycle and record
  // everything the monitor and responder need.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input int rw, input int rdl, input bit expect_rsp);
    int    n;
    int    a;
    int    sz;
    bit    mis;
    mreq_t m;
    rsp_t  r;
    mt_t   t;
    n = 0;
    @(posedge clk); #2;
    while (!req_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;

    a   = int'(addr & 32'h3);
    sz  = op_size(st, f3);
    mis = ref_misaligned(st, f3, a);
    if (!mis) begin
      m.addr = addr & 32'hFFFF_FFFC;
      m.we   = st;
      if (!st) begin
        m.mask  = 4'b0000;
        m.wdata = 32'd0;
      end else if (sz == 1) begin
        m.mask  = 4'(1 << a);
        m.wdata = (wdata & 32'hFF) * 32'h0101_0101;
      end else if (sz == 2) begin
        m.mask  = 4'(3 << (a & 2));
        m.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
      end else begin
        m.mask  = 4'hF;
        m.wdata = wdata;
      end
      mq.push_back(m);
    end
    if (expect_rsp) begin
      r.err      = mis;
      r.wb_valid = !st && !mis && (rd != 5'd0);
      r.rd       = rd;
      r.data     = ref_load(f3, a, rdata);
      r.acc_c    = cyc;
      r.done_c   = mis ? cyc + 2 : cyc + 3 + rw + rdl;
      rq.push_back(r);
      if (!mis) begin
        t.rw    = rw;
        t.rdl   = rdl;
        t.rdata = rdata;
        tq.push_back(t);
      end
    end
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_is_store = 1'($urandom);
    req_funct3   = 3'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_outstanding", rq.size() + mq.size(), 32'd0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mt_t t;
    forever begin
      @(posedge clk); #1;
      if (auto_mem && mem_req_valid) begin
        if (tq.size() == 0) begin
          check("responder_timing_queue", 32'd0, 32'd1);
        end else begin
          t = tq.pop_front();
          // Stall the request; stray responses meanwhile must be ignored.
          repeat (t.rw) begin
            auto_rsp   = 1'($urandom);
            auto_rdata = $urandom;
            @(posedge clk); #1;
          end
          auto_rsp   = 1'b0;
          auto_ready = 1'b1;
          @(posedge clk); #1;
          auto_ready = 1'b0;
          repeat (t.rdl) begin
            @(posedge clk); #1;
          end
          auto_rsp   = 1'b1;
          auto_rdata = t.rdata;
          @(posedge clk); #1;
          auto_rsp   = 1'b0;
          auto_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (chk_ready)
          check("req_ready", {31'd0, req_ready},
                {31'd0, (rq.size() == 0 || rq[0].acc_c == cyc)});
        if (mem_req_valid) begin
          if (mq.size() == 0) begin
            check("unexpected_mem_req", {31'd0, mem_req_valid}, 32'd0);
          end else begin
            check("mem_addr", mem_addr, mq[0].addr);
            check("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
            check("mem_wmask", {28'd0, mem_wmask}, {28'd0, mq[0].mask});
            if (mq[0].we) check("mem_wdata", mem_wdata, mq[0].wdata);
            if (mem_req_ready) void'(mq.pop_front());
          end
        end
        if (done) begin
          if (rq.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            r = rq.pop_front();
            check("done_cycle", cyc, r.done_c);
            check("wb_valid", {31'd0, wb_valid}, {31'd0, r.wb_valid});
            check("err", {31'd0, err}, {31'd0, r.err});
            if (r.wb_valid) begin
              check("wb_rd", {27'd0, wb_rd}, {27'd0, r.rd});
              check("wb_data", wb_data, r.data);
            end
          end
        end else begin
          if (wb_valid) check("wb_valid_without_done", {31'd0, wb_valid}, 32'd0);
          if (err) check("err_without_done", {31'd0, err}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_rd       = 5'd0;

    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    #9 rst = 1'b1;

    // Directed cases.
    issue(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd7,  32'h0,         0, 0, 1'b1);
    issue(1'b0, 3'b000, 32'h8000_0003, 32'h0,         5'd9,  32'h80FF_1234, 0, 0, 1'b1);
    issue(1'b0, 3'b100, 32'h8000_0003, 32'h0,         5'd10, 32'h80FF_1234, 0, 0, 1'b1);
    issue(1'b0, 3'b001, 32'h8000_0002, 32'h0,         5'd11, 32'h80FF_1234, 0, 0, 1'b1);
    issue(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd1,  32'h0,         0, 0, 1'b1);
    issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 5'd1,  32'h0,         0, 0, 1'b1);
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0,         5'd0,  32'h1234_5678, 0, 0, 1'b1);
    issue(1'b0, 3'b010, 32'h8000_0020, 32'h0,         5'd12, 32'hCAFE_F00D, 5, 3, 1'b1);
    issue(1'b0, 3'b010, 32'h8000_0002, 32'h0,         5'd13, 32'h0BAD_F00D, 0, 0, 1'b1);
    issue(1'b0, 3'b101, 32'h8000_0003, 32'h0,         5'd14, 32'hF00D_8001, 1, 2, 1'b1);

    // Randomized ops.
    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(st, f3, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, rd, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    // Reset while waiting for a response: outputs clear at once and the
    // late response must not retire anything.
    auto_mem  = 1'b0;
    chk_ready = 1'b0;
    man_ready = 1'b1;
    issue(1'b0, 3'b010, 32'h8000_0040, 32'h0, 5'd5, 32'h0, 0, 0, 1'b0);
    @(posedge clk); #1;
    man_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("async_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    check("async_rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
    check("async_rst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    man_rsp   = 1'b1;
    man_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    man_rsp   = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("post_rst_queues", rq.size() + mq.size(), 32'd0);
    auto_mem  = 1'b1;
    chk_ready = 1'b1;

    // The unit must still work normally after the reset.
    issue(1'b0, 3'b000, 32'h8000_0081, 32'h0, 5'd3, 32'h0000_7F00, 0, 0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
